sprite_mask_arbiter: RTL

Shares one single-port sprite mask BROM (1-bit mask, NUM_IMGS shapes of WIDTH x HEIGHT) between NUM_REQ sprite renderers.
- Each requester presents a shape index and a pixel offset relative to its sprite origin.
- The block range-checks the offset, forms the ROM address, and grants one requester per cycle using round-robin.
- After the fixed ROM latency it returns the mask bit, tagged with the requester id.
- It sits between the per-sprite draw logic and the shared mask ROM instance in the video pipeline.

---
 rtl/sprite_mask_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/sprite_mask_arbiter.sv
// Round-robin arbiter sharing one single-port sprite mask ROM between several
// renderers; each accepted request returns one tagged mask bit after ROM_LATENCY.
module sprite_mask_arbiter #(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 128,
  parameter int NUM_IMGS    = 4,
  parameter int NUM_REQ     = 4,
  parameter int ROM_LATENCY = 2
) (
  input  logic                                   pixel_clk_in,
  input  logic                                   rst_in,
  input  logic [NUM_REQ-1:0]                     req_valid_in,
  input  logic [NUM_REQ*2-1:0]                   req_shape_in,
  input  logic [NUM_REQ*11-1:0]                  req_dx_in,
  input  logic [NUM_REQ*10-1:0]                  req_dy_in,
  output logic [NUM_REQ-1:0]                     req_ready_out,
  output logic [$clog2(WIDTH*HEIGHT*NUM_IMGS)-1:0] rom_addr_out,
  output logic                                   rom_en_out,
  input  logic                                   rom_data_in,
  output logic                                   rsp_valid_out,
  output logic [$clog2(NUM_REQ)-1:0]             rsp_id_out,
  output logic                                   rsp_draw_out
);

  localparam int AW  = $clog2(WIDTH*HEIGHT*NUM_IMGS);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int L   = ROM_LATENCY;

  // Handshake: a request transfers in the cycle where req_valid_in[i] and
  // req_ready_out[i] are both 1; requesters hold valid and payload until then.
  // The response side has no backpressure and must take every rsp_valid_out pulse.

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic                    grant;
  logic [IDW-1:0]          grant_id;
  logic [IDW-1:0]          cand;
  int                      idx;
  logic [1:0]              sel_shape;
  logic [10:0]             sel_dx;
  logic [9:0]              sel_dy;
  logic                    in_range;
  logic [AW-1:0]           addr;
  logic [L-1:0]            vld_q, vld_d;
  logic [L-1:0]            inr_q, inr_d;
  logic [L-1:0][IDW-1:0]   id_q, id_d;

  // Scan from the slot after the last grant, wrapping, so the last winner is lowest priority.
  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    cand     = '0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(ptr_q) + k) % NUM_REQ;
      cand = IDW'(idx);
      if (!grant && req_valid_in[cand]) begin
        grant    = 1'b1;
        grant_id = cand;
      end
    end
  end

  always_comb begin
    sel_shape = '0;
    sel_dx    = '0;
    sel_dy    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_shape = req_shape_in[2*i +: 2];
        sel_dx    = req_dx_in[11*i +: 11];
        sel_dy    = req_dy_in[10*i +: 10];
      end
    end
  end

  always_comb begin
    in_range      = ({21'd0, sel_dx} < 32'(WIDTH)) && ({22'd0, sel_dy} < 32'(HEIGHT));
    addr          = AW'(sel_dx) + AW'(sel_dy) * AW'(WIDTH) + AW'(sel_shape) * AW'(WIDTH*HEIGHT);
    rom_en_out    = grant && in_range;
    rom_addr_out  = rom_en_out ? addr : '0;
    req_ready_out = grant ? (NUM_REQ'(1) << grant_id) : '0;
    ptr_d         = grant ? grant_id : ptr_q;
  end

  // Ids only advance with a valid token, so the last stage keeps the most recent responder id.
  always_comb begin
    vld_d    = '0;
    inr_d    = '0;
    id_d     = id_q;
    vld_d[0] = grant;
    inr_d[0] = grant && in_range;
    id_d[0]  = grant ? grant_id : id_q[0];
    for (int i = 1; i < L; i++) begin
      vld_d[i] = vld_q[i-1];
      inr_d[i] = inr_q[i-1];
      id_d[i]  = vld_q[i-1] ? id_q[i-1] : id_q[i];
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ptr_q <= IDW'(NUM_REQ-1);
      vld_q <= '0;
      inr_q <= '0;
      id_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      inr_q <= inr_d;
      id_q  <= id_d;
    end
  end

  assign rsp_valid_out = vld_q[L-1];
  assign rsp_id_out    = id_q[L-1];
  assign rsp_draw_out  = vld_q[L-1] && inr_q[L-1] && rom_data_in;

endmodule
